// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared FSM states, width defaults and the hardwired-zero register index
package wb_stage_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;
  localparam int R0 = 0;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
endpackage

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load-wait FSM and timeout; WB_STAGE_FWD_EN enables forwarding hits
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  output logic              stall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] RegDst,
  output logic [DATA_W-1:0] Mem_to_Reg,
  output logic              err,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit
);
  state_t state;
  logic [7:0] cnt;
  logic [REG_AW-1:0] rd_q;
  logic wr_q;
  assign stall = state == WAIT_MEM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      wr_q <= 1'b0;
      RegWrite <= 1'b0;
      RegDst <= '0;
      Mem_to_Reg <= '0;
      err <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      err <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && ex_is_load) begin
          state <= WAIT_MEM;
          cnt <= '0;
          rd_q <= ex_rd;
          wr_q <= ex_regwrite;
        end else if (ex_valid && ex_regwrite && ex_rd != REG_AW'(R0)) begin
          RegWrite <= 1'b1;
          RegDst <= ex_rd;
          Mem_to_Reg <= ex_alu;
        end
      end else if (mem_rvalid) begin
        state <= IDLE;
        if (wr_q && rd_q != REG_AW'(R0)) begin
          RegWrite <= 1'b1;
          RegDst <= rd_q;
          Mem_to_Reg <= mem_rdata;
        end
      end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
        state <= IDLE;
        err <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
`ifdef WB_STAGE_FWD_EN
  assign fwd_a_hit = RegWrite && RegDst == rd_a;
  assign fwd_b_hit = RegWrite && RegDst == rd_b;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_a, rd_b};
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized scoreboard bench for wb_stage; honours WB_STAGE_FWD_EN
module tb_wb_stage;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int T = 15;
`ifdef WB_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {bit is_err; int rd; int data; int cyc;} exp_t;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_regwrite = 0, ex_is_load = 0, mem_rvalid = 0;
  logic [AW-1:0] ex_rd = 0, rd_a = 0, rd_b = 0;
  logic [DW-1:0] ex_alu = 0, mem_rdata = 0;
  logic stall, RegWrite, err, fwd_a_hit, fwd_b_hit;
  logic [AW-1:0] RegDst;
  logic [DW-1:0] Mem_to_Reg;
  int checks = 0, errors = 0, cyc = 0, last_rd = 0, last_d = 0;
  bit wexp;
  exp_t q[$];
  exp_t e;
  wb_stage #(.DATA_W(DW), .REG_AW(AW), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_alu(ex_alu), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rd_a(rd_a), .rd_b(rd_b), .stall(stall), .RegWrite(RegWrite),
    .RegDst(RegDst), .Mem_to_Reg(Mem_to_Reg), .err(err), .fwd_a_hit(fwd_a_hit),
    .fwd_b_hit(fwd_b_hit));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd = 0;
      last_d = 0;
    end else begin
      wexp = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_out_cyc", cyc, e.cyc);
      end
      if (RegWrite || err) begin
        if (q.size() == 0 || q[0].cyc != cyc) chk("unexpected_out", {RegWrite, err}, 0);
        else begin
          e = q.pop_front();
          chk("err", err, e.is_err);
          chk("regwrite", RegWrite, !e.is_err);
          if (!e.is_err) begin
            chk("regdst", RegDst, e.rd);
            chk("wdata", Mem_to_Reg, e.data);
            last_rd = e.rd;
            last_d = e.data;
            wexp = 1;
          end
        end
      end else begin
        chk("hold_regdst", RegDst, last_rd);
        chk("hold_wdata", Mem_to_Reg, last_d);
      end
      chk("fwd_a", fwd_a_hit, FWD && wexp && last_rd == rd_a);
      chk("fwd_b", fwd_b_hit, FWD && wexp && last_rd == rd_b);
    end
  end
  task automatic tick(input logic es);
    @(negedge clk);
    chk("stall", stall, es);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_valid = 0;
    mem_rvalid = 1'($urandom);
    mem_rdata = DW'($urandom);
    tick(0);
  endtask
  task automatic alu(input int rd, input int d, input bit rw);
    ex_valid = 1;
    ex_is_load = 0;
    ex_regwrite = rw;
    ex_rd = AW'(rd);
    ex_alu = DW'(d);
    mem_rvalid = 1'($urandom);
    mem_rdata = DW'($urandom);
    rd_a = AW'($urandom);
    rd_b = AW'($urandom);
    if (rw && rd != 0) q.push_back('{1'b0, rd, d, cyc + 1});
    tick(0);
  endtask
  task automatic load(input int rd, input bit rw, input int w, input int d);
    ex_valid = 1;
    ex_is_load = 1;
    ex_regwrite = rw;
    ex_rd = AW'(rd);
    ex_alu = DW'($urandom);
    mem_rvalid = 1'($urandom);
    tick(0);
    if (w >= T) q.push_back('{1'b1, 0, 0, cyc + T});
    for (int i = 0; i < w && i < T; i++) begin
      ex_valid = 1'($urandom);
      ex_is_load = 1'($urandom);
      ex_regwrite = 1'($urandom);
      ex_rd = AW'($urandom);
      ex_alu = DW'($urandom);
      mem_rvalid = 0;
      rd_a = AW'($urandom);
      rd_b = AW'($urandom);
      tick(1);
    end
    if (w < T) begin
      ex_valid = 1'($urandom);
      mem_rvalid = 1;
      mem_rdata = DW'(d);
      if (rw && rd != 0) q.push_back('{1'b0, rd, d, cyc + 1});
      tick(1);
    end
    ex_valid = 0;
    mem_rvalid = 0;
  endtask
  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_regdst", RegDst, 0);
    chk("rst_wdata", Mem_to_Reg, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    alu(3, 'h5A, 1);
    idle();
    alu(0, 'hFF, 1);
    idle();
    alu(1, 'h01, 0);
    alu(1, 'h11, 1);
    alu(2, 'h22, 1);
    alu(7, 'h77, 1);
    idle();
    load(5, 1, 3, 'hC3);
    idle();
    load(2, 1, T, 'h00);
    idle();
    load(2, 1, T - 1, 'hA5);
    idle();
    load(0, 1, 2, 'h12);
    load(4, 0, 1, 'h34);
    alu(4, 'h44, 1);
    rd_a = 4;
    rd_b = 1;
    idle();
    ex_valid = 1;
    ex_is_load = 1;
    ex_regwrite = 1;
    ex_rd = 6;
    tick(0);
    ex_valid = 0;
    tick(1);
    tick(1);
    rst_n = 0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_regwrite", RegWrite, 0);
    chk("arst_regdst", RegDst, 0);
    chk("arst_wdata", Mem_to_Reg, 0);
    chk("arst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    mem_rvalid = 1;
    mem_rdata = 'h99;
    tick(0);
    mem_rvalid = 0;
    tick(0);
    repeat (300) begin
      case ($urandom_range(0, 5))
        0, 1, 2: alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        3: idle();
        default: load(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0 ? T : int'($urandom_range(0, T - 1)),
                      int'($urandom_range(0, 255)));
      endcase
    end
    repeat (3) idle();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
